// File: rtl/lsu_stage_if.sv
// lsu_stage_if: bundles the execute-side issue port, the data-memory
// req/gnt/rvalid bus and the writeback beat of the memory stage.
// slave  = the memory stage itself, master = whoever drives it.
interface lsu_stage_if #(
  parameter int unsigned XLEN = 32
) ();

  // Issue from execute
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic [2:0]      mem_op;
  logic            is_load;
  logic            is_store;
  logic            reg_we;

  // Data-memory bus
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  // Writeback
  logic            wb_valid;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            lsu_err;

  modport slave (
    input  in_valid, alu_res, rs2_data, rd_addr, mem_op, is_load, is_store, reg_we,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output in_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, lsu_err
  );

  modport master (
    output in_valid, alu_res, rs2_data, rd_addr, mem_op, is_load, is_store, reg_we,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  in_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, lsu_err
  );

endinterface

// File: rtl/lsu_stage.sv
// lsu_stage: memory stage after the execute ALU. Passes ALU results through,
// or runs one outstanding data-memory access (req/gnt then rvalid) with
// byte-lane placement for stores and sign/zero extension for loads.
// Emits exactly one registered writeback beat per accepted instruction.
// Optional macro LSU_BUS_TIMEOUT_EN: abandon a bus access that sees no
// gnt/rvalid within TIMEOUT_CYCLES and retire it with lsu_err.
module lsu_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        rst,
  lsu_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_t          r_state,      w_state_nxt;
  logic            r_in_ready,   w_in_ready_nxt;
  logic            r_req,        w_req_nxt;
  logic            r_we,         w_we_nxt;
  logic [XLEN-1:0] r_addr,       w_addr_nxt;
  logic [3:0]      r_be,         w_be_nxt;
  logic [XLEN-1:0] r_wdata,      w_wdata_nxt;
  logic [4:0]      r_rd,         w_rd_nxt;
  logic [2:0]      r_mem_op,     w_mem_op_nxt;
  logic [1:0]      r_off,        w_off_nxt;
  logic            r_wb_valid,   w_wb_valid_nxt;
  logic            r_wb_we,      w_wb_we_nxt;
  logic [4:0]      r_wb_rd,      w_wb_rd_nxt;
  logic [XLEN-1:0] r_wb_data,    w_wb_data_nxt;
  logic            r_err,        w_err_nxt;

  logic            w_accept;
  logic            w_is_mem;
  logic            w_op_legal;
  logic            w_misalign;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [XLEN-1:0] w_ld_sh;
  logic [XLEN-1:0] w_ld_data;
  logic            w_tmo_hit;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_is_mem = bus.is_load | bus.is_store;

  // Opcode legality: stores only take B/H/W, loads additionally BU/HU
  always_comb begin
    w_op_legal = 1'b0;
    case (bus.mem_op)
      OP_B, OP_H, OP_W: w_op_legal = 1'b1;
      OP_BU, OP_HU:     w_op_legal = bus.is_load;
      default:          w_op_legal = 1'b0;
    endcase
  end

  // Halfwords need even addresses, words need 4-byte alignment
  always_comb begin
    w_misalign = 1'b0;
    if (bus.mem_op[1:0] == 2'b01) begin
      w_misalign = bus.alu_res[0];
    end else if (bus.mem_op[1:0] == 2'b10) begin
      w_misalign = (bus.alu_res[1:0] != 2'b00);
    end
  end

  // Store lane placement: replicate data across lanes, enable the addressed ones
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = bus.rs2_data;
    case (bus.mem_op[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << bus.alu_res[1:0];
        w_st_wdata = {4{bus.rs2_data[7:0]}};
      end
      2'b01: begin
        w_st_be    = bus.alu_res[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{bus.rs2_data[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = bus.rs2_data;
      end
    endcase
  end

  // Load extraction: shift the addressed byte/half down, then extend
  assign w_ld_sh = bus.dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_ld_sh;
    case (r_mem_op)
      OP_B:    w_ld_data = {{(XLEN-8){w_ld_sh[7]}}, w_ld_sh[7:0]};
      OP_BU:   w_ld_data = {{(XLEN-8){1'b0}}, w_ld_sh[7:0]};
      OP_H:    w_ld_data = {{(XLEN-16){w_ld_sh[15]}}, w_ld_sh[15:0]};
      OP_HU:   w_ld_data = {{(XLEN-16){1'b0}}, w_ld_sh[15:0]};
      default: w_ld_data = w_ld_sh;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

  // Fires in the TIMEOUT_CYCLES-th cycle spent in the current bus state
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change and counts cycles in REQ/WAIT_R
  always_comb begin
    w_tmo_cnt_nxt = '0;
    if ((r_state != IDLE) && (w_state_nxt == r_state)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
    end
  end

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end
`else
  logic [31:0] w_unused_tmo;

  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_be_nxt       = r_be;
    w_wdata_nxt    = r_wdata;
    w_rd_nxt       = r_rd;
    w_mem_op_nxt   = r_mem_op;
    w_off_nxt      = r_off;
    w_wb_valid_nxt = 1'b0;
    w_wb_we_nxt    = 1'b0;
    w_wb_rd_nxt    = r_wb_rd;
    w_wb_data_nxt  = r_wb_data;
    w_err_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_is_mem) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_we_nxt    = bus.reg_we;
            w_wb_rd_nxt    = bus.rd_addr;
            w_wb_data_nxt  = bus.alu_res;
          end else if (!w_op_legal || w_misalign) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = bus.rd_addr;
            w_err_nxt      = 1'b1;
          end else begin
            w_state_nxt  = REQ;
            w_req_nxt    = 1'b1;
            w_we_nxt     = bus.is_store;
            w_addr_nxt   = {bus.alu_res[XLEN-1:2], 2'b00};
            w_be_nxt     = bus.is_store ? w_st_be : 4'b1111;
            w_wdata_nxt  = bus.is_store ? w_st_wdata : '0;
            w_rd_nxt     = bus.rd_addr;
            w_mem_op_nxt = bus.mem_op;
            w_off_nxt    = bus.alu_res[1:0];
          end
        end
      end

      REQ: begin
        if (bus.dmem_gnt) begin
          w_req_nxt = 1'b0;
          if (r_we) begin
            w_state_nxt    = IDLE;
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = r_rd;
          end else begin
            w_state_nxt = WAIT_R;
          end
        end else if (w_tmo_hit) begin
          w_req_nxt      = 1'b0;
          w_state_nxt    = IDLE;
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = r_rd;
          w_err_nxt      = 1'b1;
        end
      end

      WAIT_R: begin
        if (bus.dmem_rvalid) begin
          w_state_nxt    = IDLE;
          w_wb_valid_nxt = 1'b1;
          w_wb_we_nxt    = 1'b1;
          w_wb_rd_nxt    = r_rd;
          w_wb_data_nxt  = w_ld_data;
        end else if (w_tmo_hit) begin
          w_state_nxt    = IDLE;
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = r_rd;
          w_err_nxt      = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == IDLE);
  end

  // State, bus and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_mem_op   <= '0;
      r_off      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_be       <= w_be_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rd       <= w_rd_nxt;
      r_mem_op   <= w_mem_op_nxt;
      r_off      <= w_off_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_wb_we    <= w_wb_we_nxt;
      r_wb_rd    <= w_wb_rd_nxt;
      r_wb_data  <= w_wb_data_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_be    = r_be;
  assign bus.dmem_wdata = r_wdata;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_we      = r_wb_we;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_data    = r_wb_data;
  assign bus.lsu_err    = r_err;

endmodule
